int_ack_sequencer: RTL and testbench

- CPU-side consumer of the ICU request/vector pair.
- Holds fetch until an instruction boundary, saves the resume PC, and runs the INTA handshake with the ICU.
- Latches the vector, computes the handler address and redirects fetch to it.
- On return-from-interrupt, redirects fetch back to the saved PC; no nesting.

---
 rtl/int_ack_sequencer.sv | 138 +++++++++++++
 tb/tb_int_ack_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ack_sequencer.sv
// int_ack_sequencer: takes an ICU interrupt request on the CPU side.
// It holds fetch until the pipeline reaches an instruction boundary, saves the
// resume PC, runs the INTA handshake, redirects fetch to the vector's handler,
// and on i_iret redirects fetch back to the saved PC. Interrupts do not nest.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_intr, i_vector  request and vector from the ICU
//   o_inta            acknowledge to the ICU
//   i_ie              global interrupt enable
//   i_instr_boundary  pipeline is at a retire boundary this cycle
//   i_pc              PC of the next instruction to resume
//   i_iret            return-from-interrupt pulse
//   o_stall           hold fetch
//   o_redirect        one-cycle fetch redirect pulse, with o_target
//   o_epc             saved resume PC
//   o_in_isr          handler executing
//   o_busy            sequence in progress (not idle, not in handler)
module int_ack_sequencer #(
    parameter int unsigned          VEC_W       = 8,
    parameter int unsigned          ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]    VEC_BASE    = 32'h0000_0100,
    parameter int unsigned          VEC_SHIFT   = 2,
    parameter int unsigned          INTA_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_intr,
    input  logic [VEC_W-1:0]  i_vector,
    output logic              o_inta,
    input  logic              i_ie,
    input  logic              i_instr_boundary,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_iret,
    output logic              o_stall,
    output logic              o_redirect,
    output logic [ADDR_W-1:0] o_target,
    output logic [ADDR_W-1:0] o_epc,
    output logic              o_in_isr,
    output logic              o_busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTA_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BND = 3'd1,
        S_ACK      = 3'd2,
        S_REDIRECT = 3'd3,
        S_ISR      = 3'd4,
        S_RET      = 3'd5
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] handler_c;

    // Handler address; the add wraps modulo 2^ADDR_W by construction.
    assign handler_c = VEC_BASE + (ADDR_W'(i_vector) << VEC_SHIFT);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            o_inta     <= 1'b0;
            o_stall    <= 1'b0;
            o_redirect <= 1'b0;
            o_target   <= '0;
            o_epc      <= '0;
            o_in_isr   <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_redirect <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_intr && i_ie && !o_in_isr) begin
                        state_q <= S_WAIT_BND;
                        o_stall <= 1'b1;
                        o_busy  <= 1'b1;
                    end
                end
                S_WAIT_BND: begin
                    // Abort wins over a boundary seen in the same cycle.
                    if (!i_intr || !i_ie) begin
                        state_q <= S_IDLE;
                        o_stall <= 1'b0;
                        o_busy  <= 1'b0;
                    end else if (i_instr_boundary) begin
                        state_q <= S_ACK;
                        o_epc   <= i_pc;
                        cnt_q   <= '0;
                        o_inta  <= 1'b1;
                    end
                end
                S_ACK: begin
                    // Committed: request/enable changes are ignored here.
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= S_REDIRECT;
                        o_inta     <= 1'b0;
                        o_redirect <= 1'b1;
                        o_target   <= handler_c;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_REDIRECT: begin
                    state_q  <= S_ISR;
                    o_in_isr <= 1'b1;
                    o_stall  <= 1'b0;
                    o_busy   <= 1'b0;
                end
                S_ISR: begin
                    if (i_iret) begin
                        state_q    <= S_RET;
                        o_redirect <= 1'b1;
                        o_target   <= o_epc;
                        o_busy     <= 1'b1;
                    end
                end
                S_RET: begin
                    state_q  <= S_IDLE;
                    o_in_isr <= 1'b0;
                    o_busy   <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    o_inta   <= 1'b0;
                    o_stall  <= 1'b0;
                    o_in_isr <= 1'b0;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Testbench for int_ack_sequencer: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_int_ack_sequencer;

    localparam int unsigned INTA = 2;
    localparam logic [31:0] BASE0 = 32'h0000_0100;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        intr = 1'b0;
    logic [7:0]  vec = '0;
    logic        ie = 1'b0;
    logic        bnd = 1'b0;
    logic [31:0] pc = '0;
    logic        iret = 1'b0;

    logic        inta0, stall0, redir0, isr0, busy0;
    logic [31:0] target0, epc0;
    logic        inta1, stall1, redir1, isr1, busy1;
    logic [31:0] target1, epc1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int_ack_sequencer #(.VEC_BASE(BASE0), .INTA_CYCLES(INTA)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_intr(intr), .i_vector(vec),
        .o_inta(inta0), .i_ie(ie), .i_instr_boundary(bnd), .i_pc(pc),
        .i_iret(iret), .o_stall(stall0), .o_redirect(redir0),
        .o_target(target0), .o_epc(epc0), .o_in_isr(isr0), .o_busy(busy0)
    );

    int_ack_sequencer #(.VEC_BASE(BASE1), .INTA_CYCLES(INTA)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_intr(intr), .i_vector(vec),
        .o_inta(inta1), .i_ie(ie), .i_instr_boundary(bnd), .i_pc(pc),
        .i_iret(iret), .o_stall(stall1), .o_redirect(redir1),
        .o_target(target1), .o_epc(epc1), .o_in_isr(isr1), .o_busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Sequence described by what is outstanding: a boundary wait, a number of
    // acknowledge cycles left, a pending redirect pulse (entry or return).
    bit          m_waiting   = 0;
    int          m_ack_left  = 0;
    bit          m_pulse     = 0;
    bit          m_returning = 0;
    bit          m_handler   = 0;
    logic [31:0] m_epc       = '0;
    logic [31:0] m_tgt0      = '0;
    logic [31:0] m_tgt1      = '0;

    function automatic logic [31:0] handler(input logic [31:0] base, input logic [7:0] v);
        longint unsigned a;
        a = longint'(base) + longint'(v) * 4;
        return a[31:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting = 0; m_ack_left = 0; m_pulse = 0; m_returning = 0;
            m_handler = 0; m_epc = '0;
        end else if (m_pulse) begin
            m_pulse = 0;
            m_handler = !m_returning;
            m_returning = 0;
        end else if (m_ack_left > 0) begin
            m_ack_left--;
            if (m_ack_left == 0) begin
                m_pulse = 1;
                m_tgt0 = handler(BASE0, vec);
                m_tgt1 = handler(BASE1, vec);
            end
        end else if (m_waiting) begin
            if (!intr || !ie) m_waiting = 0;
            else if (bnd) begin
                m_waiting = 0;
                m_epc = pc;
                m_ack_left = INTA;
            end
        end else if (m_handler) begin
            if (iret) begin
                m_pulse = 1;
                m_returning = 1;
                m_tgt0 = m_epc;
                m_tgt1 = m_epc;
            end
        end else if (intr && ie) begin
            m_waiting = 1;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic e_inta, e_stall, e_busy;
        e_inta  = (m_ack_left > 0);
        e_stall = m_waiting || e_inta || (m_pulse && !m_returning);
        e_busy  = m_waiting || e_inta || m_pulse;
        chk("m_inta",   32'(inta0),  32'(e_inta));
        chk("m_stall",  32'(stall0), 32'(e_stall));
        chk("m_busy",   32'(busy0),  32'(e_busy));
        chk("m_redir",  32'(redir0), 32'(m_pulse));
        chk("m_in_isr", 32'(isr0),   32'(m_handler));
        chk("m_epc",    epc0,        m_epc);
        chk("m_redir1", 32'(redir1), 32'(m_pulse));
        chk("m_epc1",   epc1,        m_epc);
        if (m_pulse) begin
            chk("m_target0", target0, m_tgt0);
            chk("m_target1", target1, m_tgt1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_inta", 32'(inta0), 0);
        chk("rst_stall", 32'(stall0), 0);
        chk("rst_epc", epc0, 0);
        chk("rst_target", target0, 0);
        rst_n = 1'b1;
        tick();

        // Basic entry
        intr = 1; ie = 1; bnd = 1; pc = 32'h40; vec = 8'h01;
        tick();
        chk("e1_stall", 32'(stall0), 1);
        chk("e1_inta", 32'(inta0), 0);
        tick();
        chk("e2_inta", 32'(inta0), 1);
        chk("e2_epc", epc0, 32'h40);
        bnd = 0; pc = 32'h999;
        tick();
        chk("e3_inta", 32'(inta0), 1);
        tick();
        chk("e4_redir", 32'(redir0), 1);
        chk("e4_target", target0, 32'h104);
        chk("e4_target1", target1, 32'hFFFF_FFF4);
        chk("e4_inta", 32'(inta0), 0);
        tick();
        chk("e5_in_isr", 32'(isr0), 1);
        chk("e5_redir", 32'(redir0), 0);
        repeat (3) tick();
        chk("nonest_stall", 32'(stall0), 0);

        // Return, then the held request is taken
        iret = 1;
        tick();
        chk("ret_redir", 32'(redir0), 1);
        chk("ret_target", target0, 32'h40);
        iret = 0;
        tick();
        chk("ret_in_isr", 32'(isr0), 0);
        chk("ret_redir_off", 32'(redir0), 0);
        tick();
        chk("second_stall", 32'(stall0), 1);

        // Boundary delay
        repeat (5) begin
            tick();
            chk("bnd_wait_inta", 32'(inta0), 0);
        end
        pc = 32'h80; bnd = 1; vec = 8'h10;
        tick();
        chk("bnd_inta", 32'(inta0), 1);
        chk("bnd_epc", epc0, 32'h80);
        bnd = 0;
        tick();
        tick();
        chk("bnd_target", target0, 32'h140);
        tick();
        intr = 0;
        iret = 1;
        tick();
        iret = 0;
        tick();

        // Abort
        intr = 1;
        tick();
        chk("abort_stall_on", 32'(stall0), 1);
        intr = 0;
        tick();
        chk("abort_stall_off", 32'(stall0), 0);
        chk("abort_epc", epc0, 32'h80);
        tick();
        chk("abort_inta", 32'(inta0), 0);

        // iret in IDLE
        iret = 1;
        tick();
        chk("idle_iret", 32'(redir0), 0);
        iret = 0;

        // Wrap
        intr = 1; bnd = 1; vec = 8'h05;
        repeat (4) tick();
        chk("wrap_redir1", 32'(redir1), 1);
        chk("wrap_target1", target1, 32'h0000_0004);
        chk("wrap_target0", target0, 32'h114);
        intr = 0; bnd = 0;
        tick();
        iret = 1;
        tick();
        iret = 0;
        tick();

        // Reset mid-ACK
        intr = 1; bnd = 1;
        tick();
        tick();
        chk("rma_inta_pre", 32'(inta0), 1);
        #2 rst_n = 0;
        #1;
        chk("rma_inta", 32'(inta0), 0);
        chk("rma_stall", 32'(stall0), 0);
        chk("rma_busy", 32'(busy0), 0);
        intr = 0; bnd = 0;
        #2 rst_n = 1;
        repeat (3) begin
            tick();
            chk("rma_redir", 32'(redir0), 0);
            chk("rma_busy_after", 32'(busy0), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            intr = ($urandom_range(0, 9) < 7);
            ie   = ($urandom_range(0, 19) < 17);
            bnd  = ($urandom_range(0, 9) < 4);
            iret = ($urandom_range(0, 19) < 3);
            pc   = $urandom() & 32'hFFFF_FFFC;
            vec  = 8'($urandom());
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 0;
                #1 rst_n = 1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
